// File: rtl/ncl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ncl_pkg
// Brief  : Shared NCL constants and the count-width helper.
// Rev    : 1.0  initial release
// ============================================================================
package ncl_pkg;

  localparam int   NCL_MAX_N = 16;
  localparam logic NCL_NULL  = 1'b0;
  localparam logic NCL_DATA  = 1'b1;

  // Smallest w with 2**w >= value; clog2(N+1) bits hold a count of 0..N.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : ncl_pkg
`default_nettype wire

// File: rtl/ncl_th_gate_if.sv
`default_nettype none
// ============================================================================
// Module : ncl_th_gate_if
// Brief  : Gate input rails and registered output of one threshold gate.
// Rev    : 1.0  initial release
// ============================================================================
interface ncl_th_gate_if #(
  parameter int N = 2
) ();

  logic [N-1:0] a;
  logic         z;

  modport master (output a, input  z);
  modport slave  (input  a, output z);

endinterface : ncl_th_gate_if
`default_nettype wire

// File: rtl/ncl_popcount.sv
`default_nettype none
// ============================================================================
// Module : ncl_popcount
// Brief  : Combinational count of asserted bits, all inputs weight 1.
// Rev    : 1.0  initial release
// ============================================================================
module ncl_popcount
  import ncl_pkg::*;
#(
  parameter int N = 2,
  parameter int W = clog2(N + 1)
) (
  input  logic [N-1:0] a_i,
  output logic [W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      cnt_o = cnt_o + W'(a_i[i]);
    end
  end

endmodule : ncl_popcount
`default_nettype wire

// File: rtl/ncl_th_gate.sv
`default_nettype none
// ============================================================================
// Module : ncl_th_gate
// Brief  : THmn threshold gate with hysteresis: set at >= M inputs, clear at 0.
// Rev    : 1.0  initial release
// ============================================================================
module ncl_th_gate
  import ncl_pkg::*;
#(
  parameter int   M        = 1,
  parameter int   N        = 2,
  parameter logic INIT_VAL = NCL_NULL
) (
  input  logic          clk,
  input  logic          init,
  ncl_th_gate_if.slave  gate
);

  localparam int CNT_W = clog2(N + 1);

  generate
    if ((M < 1) || (M > N) || (N < 1) || (N > NCL_MAX_N)) begin : g_param_err
      $error("ncl_th_gate: illegal parameters M=%0d N=%0d", M, N);
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic             z_q;
  logic             z_d;

  ncl_popcount #(
    .N (N),
    .W (CNT_W)
  ) u_popcount (
    .a_i   (gate.a),
    .cnt_o (cnt)
  );

  // Set wins over clear; with M >= 1 they can never both be true.
  always_comb begin
    z_d = z_q;
    if (cnt >= CNT_W'(M)) begin
      z_d = NCL_DATA;
    end else if (cnt == '0) begin
      z_d = NCL_NULL;
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      z_q <= INIT_VAL;
    end else begin
      z_q <= z_d;
    end
  end

  assign gate.z = z_q;

endmodule : ncl_th_gate
`default_nettype wire

// File: tb/tb_ncl_th_gate.sv
`default_nettype none
// ============================================================================
// Module : tb_ncl_th_gate
// Brief  : Directed gate-family checks plus a random wavefront sweep N=1..16.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ncl_th_gate;

  localparam int NUM_SW = 136;

  logic clk;
  logic dir_init;
  logic sw_init;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed instances: TH22, TH22 resetting to DATA, TH12, TH14
  logic [1:0] d22_a;
  logic [1:0] d12_a;
  logic [3:0] d14_a;
  logic       d22_z, d22i1_z, d12_z, d14_z;

  ncl_th_gate_if #(.N(2)) d22_if ();
  ncl_th_gate_if #(.N(2)) d22i1_if ();
  ncl_th_gate_if #(.N(2)) d12_if ();
  ncl_th_gate_if #(.N(4)) d14_if ();

  assign d22_if.a   = d22_a;
  assign d22i1_if.a = d22_a;
  assign d12_if.a   = d12_a;
  assign d14_if.a   = d14_a;
  assign d22_z      = d22_if.z;
  assign d22i1_z    = d22i1_if.z;
  assign d12_z      = d12_if.z;
  assign d14_z      = d14_if.z;

  ncl_th_gate #(.M(2), .N(2), .INIT_VAL(1'b0)) u_th22 (
    .clk(clk), .init(dir_init), .gate(d22_if));
  ncl_th_gate #(.M(2), .N(2), .INIT_VAL(1'b1)) u_th22_i1 (
    .clk(clk), .init(dir_init), .gate(d22i1_if));
  ncl_th_gate #(.M(1), .N(2), .INIT_VAL(1'b0)) u_th12 (
    .clk(clk), .init(dir_init), .gate(d12_if));
  ncl_th_gate #(.M(1), .N(4), .INIT_VAL(1'b0)) u_th14 (
    .clk(clk), .init(dir_init), .gate(d14_if));

  // Sweep instances, index = N*(N-1)/2 + M-1
  logic [15:0] sw_a  [0:NUM_SW-1];
  logic        sw_z  [0:NUM_SW-1];
  bit          sw_mz [0:NUM_SW-1];
  bit          sw_ph [0:NUM_SW-1];
  int          sw_n  [0:NUM_SW-1];
  int          sw_m  [0:NUM_SW-1];

  for (genvar gn = 1; gn <= 16; gn++) begin : g_n
    for (genvar gm = 1; gm <= gn; gm++) begin : g_m
      localparam int IDX = gn * (gn - 1) / 2 + gm - 1;
      ncl_th_gate_if #(.N(gn)) sw_if ();
      assign sw_if.a  = sw_a[IDX][gn-1:0];
      assign sw_z[IDX] = sw_if.z;
      ncl_th_gate #(.M(gm), .N(gn), .INIT_VAL(1'b0)) u_dut (
        .clk(clk), .init(sw_init), .gate(sw_if));
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  // Threshold rule stated directly: count the ones and compare against M.
  function automatic bit model_next(input logic [15:0] a, input int n,
                                    input int m, input bit z);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (a[i]) cnt++;
    end
    if (cnt >= m) return 1'b1;
    if (cnt == 0) return 1'b0;
    return z;
  endfunction

  logic [1:0] t22_a [0:4] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b10};
  logic       t22_z [0:4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] t12_a [0:4] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
  logic       t12_z [0:4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] t14_a [0:7] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                              4'b0100, 4'b0000, 4'b1000, 4'b0000};
  logic       t14_z [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mask;
    logic [15:0] sparse;
    checks   = 0;
    errors   = 0;
    dir_init = 1'b1;
    sw_init  = 1'b1;
    d22_a    = 2'b00;
    d12_a    = 2'b00;
    d14_a    = 4'b0000;
    for (int n = 1; n <= 16; n++) begin
      for (int m = 1; m <= n; m++) begin
        sw_n[n*(n-1)/2 + m-1] = n;
        sw_m[n*(n-1)/2 + m-1] = m;
      end
    end
    for (int i = 0; i < NUM_SW; i++) begin
      sw_a[i]  = '0;
      sw_mz[i] = 1'b0;
      sw_ph[i] = 1'b0;
    end

    // Reset state, and reset must dominate clock and inputs
    #1;
    chk("reset th22", d22_z, 1'b0);
    chk("reset th22 init1", d22i1_z, 1'b1);
    d22_a = 2'b11;
    d12_a = 2'b11;
    repeat (2) @(negedge clk);
    chk("reset hold th22", d22_z, 1'b0);
    chk("reset hold th22 init1", d22i1_z, 1'b1);
    chk("reset hold th12", d12_z, 1'b0);
    d22_a    = 2'b00;
    d12_a    = 2'b00;
    dir_init = 1'b0;
    @(negedge clk);
    chk("release th22", d22_z, 1'b0);
    chk("release th22 init1", d22i1_z, 1'b0);

    for (int i = 0; i < 5; i++) begin
      d22_a = t22_a[i];
      @(negedge clk);
      chk($sformatf("th22 step%0d", i), d22_z, t22_z[i]);
    end
    for (int i = 0; i < 5; i++) begin
      d12_a = t12_a[i];
      @(negedge clk);
      chk($sformatf("th12 step%0d", i), d12_z, t12_z[i]);
    end
    for (int i = 0; i < 8; i++) begin
      d14_a = t14_a[i];
      @(negedge clk);
      chk($sformatf("th14 step%0d", i), d14_z, t14_z[i]);
    end

    // Asynchronous reset between edges while DATA is held
    d22_a = 2'b11;
    @(negedge clk);
    chk("pre-reset th22", d22_z, 1'b1);
    #2 dir_init = 1'b1;
    #1;
    chk("async reset th22", d22_z, 1'b0);
    chk("async reset th22 init1", d22i1_z, 1'b1);
    #1 dir_init = 1'b0;
    @(negedge clk);
    chk("post-reset th22", d22_z, 1'b1);

    d22_a = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("hold th22 cyc%0d", i), d22_z, 1'b1);
    end
    d22_a = 2'b00;
    @(negedge clk);
    chk("hold release th22", d22_z, 1'b0);

    // Random monotonic wavefronts over every legal (N, M)
    sw_init = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_SW; i++) begin
        chk($sformatf("sweep N%0d M%0d cyc%0d", sw_n[i], sw_m[i], cyc),
            sw_z[i], sw_mz[i]);
      end
      if ($urandom_range(0, 49) == 0) begin
        sw_init = 1'b1;
        #1;
        for (int i = 0; i < NUM_SW; i++) begin
          chk($sformatf("sweep reset N%0d M%0d cyc%0d", sw_n[i], sw_m[i], cyc),
              sw_z[i], 1'b0);
          sw_mz[i] = 1'b0;
        end
        sw_init = 1'b0;
      end
      for (int i = 0; i < NUM_SW; i++) begin
        mask   = 16'((32'h1 << sw_n[i]) - 1);
        sparse = 16'($urandom) & 16'($urandom);
        if (!sw_ph[i]) begin
          sw_a[i] = (sw_a[i] | sparse) & mask;
          if ($urandom_range(0, 7) == 0) sw_a[i] = mask;
          if (sw_a[i] == mask || $urandom_range(0, 5) == 0) sw_ph[i] = 1'b1;
        end else begin
          sw_a[i] = sw_a[i] & ~sparse;
          if ($urandom_range(0, 7) == 0) sw_a[i] = '0;
          if (sw_a[i] == '0) sw_ph[i] = 1'b0;
        end
        sw_mz[i] = model_next(sw_a[i], sw_n[i], sw_m[i], sw_mz[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ncl_th_gate
`default_nettype wire
